step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- NUM_STEPS, default 16: pattern length; power of two, 2..64.
- NUM_CH, default 4: tone channels, 1..8.
- TICK_DIV, default 20000000: clock cycles per step; at least 4.
- TONE_W, default 32: tone divider width.

REQ-002 The block SHALL have these ports (SW = clog2(NUM_STEPS)):
- clock  in  1  single clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- run  in  1  level: 1 = play, 0 = pause.
- pat_we  in  1  pattern write strobe.
- pat_step  in  SW  step row to write.
- pat_data  in  NUM_CH  row data, bit c = channel c on.
- seq_len  in  SW+1  active loop length; 0 = NUM_STEPS.
- tone_div  in  NUM_CH*TONE_W  per-channel half-period in cycles; channel c uses bits [c*TONE_W +: TONE_W].
- step  out  SW  current step index.
- step_onehot  out  NUM_STEPS  one-hot of step, for LEDs.
- tick  out  1  one-cycle pulse on each step advance.
- gate  out  NUM_CH  channels active on the current step.
- speaker  out  NUM_CH  square-wave output per channel.

Function
REQ-003 Pattern storage SHALL be NUM_STEPS x NUM_CH flops; when pat_we=1, row pat_step SHALL take pat_data at the clock edge, whether running or paused.
REQ-004 The FSM SHALL have two states, STOPPED and RUNNING; it SHALL go STOPPED->RUNNING at the edge where run=1, and RUNNING->STOPPED at the edge where run=0.
REQ-005 In STOPPED, the tick counter SHALL be held at TICK_DIV-1, step SHALL hold its value (pause, not rewind), and tick SHALL be 0.
REQ-006 In RUNNING, the tick counter SHALL decrement each cycle.
REQ-007 At the edge where the tick counter is 0 in RUNNING, the block SHALL reload the counter to TICK_DIV-1, advance step, and register tick=1 for exactly the following cycle.
REQ-008 The step dwell SHALL be exactly TICK_DIV cycles.
REQ-009 Step advance SHALL wrap to 0 when step >= eff_len-1, where eff_len = NUM_STEPS if seq_len is 0 or seq_len > NUM_STEPS, else seq_len.
REQ-010 If seq_len is lowered below the current step, the next advance SHALL go to 0.
REQ-011 gate SHALL be combinational: pattern[step] AND (state==RUNNING), with no added latency.
REQ-012 A write to the current step row SHALL be visible on gate in the cycle after the write edge.
REQ-013 Each channel SHALL have a TONE_W down-counter that reloads to tone_div_c-1 at 0.
REQ-014 speaker[c] SHALL toggle at each reload while gate[c]=1.
REQ-015 speaker[c] SHALL be forced to 0, and its counter reloaded, in any cycle where gate[c]=0.
REQ-016 tone_div_c=0 SHALL give silence (speaker[c]=0); tone_div_c=1 SHALL toggle speaker[c] every cycle.
REQ-017 step_onehot SHALL equal 1<<step at all times.

Reset
REQ-018 While reset_n=0, asynchronously: state=STOPPED, step=0, tick=0, speaker=0, all tone counters=0, tick counter=TICK_DIV-1, all pattern rows=0.
REQ-019 Consequently gate=0 and step_onehot=1 during reset.
REQ-020 Reset asserted mid-run SHALL abort immediately; after release the block SHALL wait for run=1 with no residual tick.

Configuration
REQ-021 The macro SEQ_SWING_EN, when defined, SHALL set the dwell on even steps to TICK_DIV + TICK_DIV/4 cycles and on odd steps to TICK_DIV - TICK_DIV/4 cycles (integer division), keeping each pair at 2*TICK_DIV cycles.
REQ-022 Without SEQ_SWING_EN, every dwell SHALL be TICK_DIV cycles and no swing logic SHALL be synthesised.
REQ-023 Resuming from pause SHALL use the full dwell of the current step in both builds.

Verification (TICK_DIV=4, NUM_STEPS=16, NUM_CH=4)
REQ-024 Write row 2 = 4'b0101, run=1, seq_len=0 -> tick every 4 cycles; step 0,1,..15,0; gate=4'b0101 only while step=2.
REQ-025 seq_len=3 while running -> step cycles 0,1,2,0; lower seq_len to 2 while step=2 -> next step 0.
REQ-026 Deassert run at step 5 -> step holds 5, gate=0, speaker=0, tick=0; reassert -> first tick after exactly 4 cycles, then step 6.
REQ-027 Channel 0 with tone_div=3, gate high -> speaker[0] toggles every 3 cycles (period 6); tone_div=0 -> speaker[0] stays 0.
REQ-028 Assert reset_n=0 mid-run with a pattern loaded -> all outputs go to reset values without a clock edge; the pattern reads back all zero.
REQ-029 With SEQ_SWING_EN defined -> dwell 5 cycles on even steps, 3 on odd steps; without it -> 4 cycles on every step.

Source files
------------

// File: rtl/step_sequencer.sv
// Pattern step sequencer: NUM_STEPS x NUM_CH pattern, tick-divided step clock, per-channel square-wave tones.
// Define SEQ_SWING_EN to lengthen even steps and shorten odd steps by TICK_DIV/4 (swing feel).
module step_sequencer #(
   parameter int NUM_STEPS = 16,
   parameter int NUM_CH    = 4,
   parameter int TICK_DIV  = 20000000,
   parameter int TONE_W    = 32,
   localparam int SW       = $clog2(NUM_STEPS)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     run,
   input  logic                     pat_we,
   input  logic [SW-1:0]            pat_step,
   input  logic [NUM_CH-1:0]        pat_data,
   input  logic [SW:0]              seq_len,
   input  logic [NUM_CH*TONE_W-1:0] tone_div,
   output logic [SW-1:0]            step,
   output logic [NUM_STEPS-1:0]     step_onehot,
   output logic                     tick,
   output logic [NUM_CH-1:0]        gate,
   output logic [NUM_CH-1:0]        speaker
);

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } state_e;

`ifdef SEQ_SWING_EN
   localparam int CNT_W = $clog2(TICK_DIV + TICK_DIV / 4);
`else
   localparam int CNT_W = $clog2(TICK_DIV);
`endif

   localparam logic [SW:0] FULL_LEN = (SW + 1)'(NUM_STEPS);

   state_e              state_q;
   logic [CNT_W-1:0]    tick_cnt_q;
   logic [CNT_W-1:0]    reload_cur;
   logic [CNT_W-1:0]    reload_nxt;
   logic [SW-1:0]       step_q;
   logic [SW-1:0]       step_d;
   logic                tick_q;
   logic [SW:0]         eff_len;
   logic [NUM_CH-1:0]   pattern_q [NUM_STEPS];

   // NOTE: every always_comb output gets a default assignment first so no path can leave it unassigned and infer a latch.
   always_comb begin
      eff_len = seq_len;
      if (seq_len == '0 || seq_len > FULL_LEN) begin
         eff_len = FULL_LEN;
      end
      step_d = step_q + 1'b1;
      if ({1'b0, step_q} >= eff_len - 1'b1) begin
         step_d = '0;
      end
   end

   // Dwell reload for the step being held (pause/resume) and for the step being entered on advance.
`ifdef SEQ_SWING_EN
   localparam logic [CNT_W-1:0] RELOAD_EVEN = CNT_W'(TICK_DIV + TICK_DIV / 4 - 1);
   localparam logic [CNT_W-1:0] RELOAD_ODD  = CNT_W'(TICK_DIV - TICK_DIV / 4 - 1);
   assign reload_cur = step_q[0] ? RELOAD_ODD : RELOAD_EVEN;
   assign reload_nxt = step_d[0] ? RELOAD_ODD : RELOAD_EVEN;
`else
   assign reload_cur = CNT_W'(TICK_DIV - 1);
   assign reload_nxt = CNT_W'(TICK_DIV - 1);
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= STOPPED;
         tick_cnt_q <= CNT_W'(TICK_DIV - 1);
         step_q     <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         case (state_q)
            STOPPED: begin
               tick_cnt_q <= reload_cur;
               if (run) begin
                  state_q <= RUNNING;
               end
            end
            RUNNING: begin
               if (!run) begin
                  state_q    <= STOPPED;
                  tick_cnt_q <= reload_cur;
               end else if (tick_cnt_q == '0) begin
                  tick_cnt_q <= reload_nxt;
                  step_q     <= step_d;
                  tick_q     <= 1'b1;
               end else begin
                  tick_cnt_q <= tick_cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: the pattern array is reset explicitly because a reset must read back as an empty pattern.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_STEPS; r++) begin
            pattern_q[r] <= '0;
         end
      end else if (pat_we) begin
         pattern_q[pat_step] <= pat_data;
      end
   end

   assign gate        = pattern_q[step_q] & {NUM_CH{state_q == RUNNING}};
   assign step        = step_q;
   assign step_onehot = NUM_STEPS'(1) << step_q;
   assign tick        = tick_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [TONE_W-1:0] div_c;
      logic [TONE_W-1:0] tone_cnt_q;
      logic              spk_q;

      assign div_c = tone_div[c*TONE_W +: TONE_W];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            tone_cnt_q <= '0;
            spk_q      <= 1'b0;
         end else if (!gate[c] || div_c == '0) begin
            tone_cnt_q <= div_c - 1'b1;
            spk_q      <= 1'b0;
         end else if (tone_cnt_q == '0) begin
            tone_cnt_q <= div_c - 1'b1;
            spk_q      <= ~spk_q;
         end else begin
            tone_cnt_q <= tone_cnt_q - 1'b1;
         end
      end

      // Masking keeps the output silent in the very cycle gate drops, before the flop clears.
      assign speaker[c] = spk_q & gate[c] & (div_c != '0);
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a cycle-counting reference model queues expected step advances,
// a negedge monitor compares ticks, step, gate and speaker outputs against it.
module tb_step_sequencer;

   localparam int NUM_STEPS = 16;
   localparam int NUM_CH    = 4;
   localparam int TICK_DIV  = 4;
   localparam int TONE_W    = 8;
   localparam int SW        = 4;
`ifdef SEQ_SWING_EN
   localparam int SWING = 1;
`else
   localparam int SWING = 0;
`endif

   logic                     clock;
   logic                     reset_n;
   logic                     run;
   logic                     pat_we;
   logic [SW-1:0]            pat_step;
   logic [NUM_CH-1:0]        pat_data;
   logic [SW:0]              seq_len;
   logic [NUM_CH*TONE_W-1:0] tone_div;
   logic [SW-1:0]            step;
   logic [NUM_STEPS-1:0]     step_onehot;
   logic                     tick;
   logic [NUM_CH-1:0]        gate;
   logic [NUM_CH-1:0]        speaker;

   step_sequencer #(
      .NUM_STEPS (NUM_STEPS),
      .NUM_CH    (NUM_CH),
      .TICK_DIV  (TICK_DIV),
      .TONE_W    (TONE_W)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .run         (run),
      .pat_we      (pat_we),
      .pat_step    (pat_step),
      .pat_data    (pat_data),
      .seq_len     (seq_len),
      .tone_div    (tone_div),
      .step        (step),
      .step_onehot (step_onehot),
      .tick        (tick),
      .gate        (gate),
      .speaker     (speaker)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int                cyc;
      int                stp;
      logic [NUM_CH-1:0] g;
   } tick_t;

   tick_t             exp_q[$];
   logic [NUM_CH-1:0] m_pat [NUM_STEPS];
   int                m_step    = 0;
   bit                m_run     = 1'b0;
   int                m_elapsed = 0;
   int                m_on [NUM_CH];
   int                cyc       = 0;

   function automatic int dwell(input int s);
      return TICK_DIV + SWING * (((s % 2) == 0) ? (TICK_DIV / 4) : -(TICK_DIV / 4));
   endfunction

   function automatic int next_step(input int s, input int sl);
      int len;
      len = (sl == 0 || sl > NUM_STEPS) ? NUM_STEPS : sl;
      return (s >= len - 1) ? 0 : s + 1;
   endfunction

   function automatic int div_of(input int c);
      return int'(tone_div[c*TONE_W +: TONE_W]);
   endfunction

   initial begin
      logic [NUM_CH-1:0] g_before;
      tick_t             e;
      foreach (m_pat[r]) m_pat[r] = '0;
      foreach (m_on[c]) m_on[c] = 0;
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            foreach (m_pat[r]) m_pat[r] = '0;
            foreach (m_on[c]) m_on[c] = 0;
            m_step    = 0;
            m_run     = 1'b0;
            m_elapsed = 0;
            exp_q.delete();
         end else begin
            cyc++;
            g_before = m_run ? m_pat[m_step] : '0;
            for (int c = 0; c < NUM_CH; c++) begin
               if (g_before[c] && div_of(c) != 0) m_on[c]++;
               else m_on[c] = 0;
            end
            if (pat_we) m_pat[pat_step] = pat_data;
            if (!m_run) begin
               if (run) begin
                  m_run     = 1'b1;
                  m_elapsed = 0;
               end
            end else if (!run) begin
               m_run = 1'b0;
            end else begin
               m_elapsed++;
               if (m_elapsed >= dwell(m_step)) begin
                  m_step    = next_step(m_step, int'(seq_len));
                  m_elapsed = 0;
                  e.cyc = cyc;
                  e.stp = m_step;
                  e.g   = m_pat[m_step];
                  exp_q.push_back(e);
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      tick_t                e;
      logic [NUM_CH-1:0]    g_now;
      logic [NUM_CH-1:0]    spk_exp;
      logic [NUM_STEPS-1:0] oh;
      int                   d;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            g_now = m_run ? m_pat[m_step] : '0;
            for (int c = 0; c < NUM_CH; c++) begin
               d = div_of(c);
               spk_exp[c] = g_now[c] && d != 0 && ((m_on[c] / d) % 2 == 1);
            end
            oh = '0;
            oh[m_step] = 1'b1;
            check("step", step, m_step);
            check("step_onehot", step_onehot, oh);
            check("gate", gate, g_now);
            check("speaker", speaker, spk_exp);
            if (tick) begin
               if (exp_q.size() == 0) begin
                  check("spurious_tick", tick, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("tick_cycle", cyc, e.cyc);
                  check("tick_step", step, e.stp);
                  check("tick_gate", gate, e.g);
               end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               check("missed_tick", tick, 1'b1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic write_row(input int r, input logic [NUM_CH-1:0] d);
      pat_we   = 1'b1;
      pat_step = SW'(r);
      pat_data = d;
      cycles(1);
      pat_we   = 1'b0;
   endtask

   task automatic wait_step(input int target, input int budget, input string name);
      int n = 0;
      while (int'(step) != target && n < budget) begin
         cycles(1);
         n++;
      end
      check(name, step, target);
   endtask

   task automatic wait_tick(input int budget, input string name);
      int n = 0;
      while (tick !== 1'b1 && n < budget) begin
         cycles(1);
         n++;
      end
      check(name, tick, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_step"}, step, 0);
      check({tag, "_onehot"}, step_onehot, 1);
      check({tag, "_tick"}, tick, 0);
      check({tag, "_gate"}, gate, 0);
      check({tag, "_speaker"}, speaker, 0);
   endtask

   initial begin
      int                n;
      logic [NUM_CH-1:0] acc;
      logic              acc1;
      reset_n  = 1'b0;
      run      = 1'b0;
      pat_we   = 1'b0;
      pat_step = '0;
      pat_data = '0;
      seq_len  = '0;
      tone_div = {8'd5, 8'd2, 8'd1, 8'd3};

      cycles(2);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      cycles(2);

      // Basic loop with one gated row.
      write_row(2, 4'b0101);
      run = 1'b1;
      wait_step(2, 40, "reach_step2");
      check("row2_gate", gate, 4'b0101);
      wait_step(0, 120, "wrap_to_0");
      cycles(10);

      // Shortened loop, then loop length lowered below the current step.
      seq_len = 5'd3;
      wait_step(2, 100, "len3_reach2");
      seq_len = 5'd2;
      wait_tick(20, "len2_tick");
      check("len_lowered_step", step, 0);
      cycles(20);
      seq_len = '0;

      // Pause and resume.
      wait_step(5, 200, "reach_step5");
      run = 1'b0;
      cycles(3);
      check("pause_step", step, 5);
      check("pause_gate", gate, 0);
      check("pause_speaker", speaker, 0);
      check("pause_tick", tick, 0);
      run = 1'b1;
      cycles(1);
      n = 0;
      do begin
         cycles(1);
         n++;
      end while (tick !== 1'b1 && n < 20);
      check("resume_dwell", n, dwell(5));
      check("resume_step", step, 6);

      // Channel 0 tone with divider 3: toggles every 3 cycles.
      run = 1'b0;
      cycles(2);
      for (int r = 0; r < NUM_STEPS; r++) write_row(r, 4'b0001);
      run = 1'b1;
      cycles(1);
      for (int i = 0; i < 12; i++) begin
         check("tone3_wave", speaker[0], ((i / 3) % 2));
         cycles(1);
      end

      // Divider 0 means silence.
      run = 1'b0;
      cycles(2);
      tone_div[7:0] = 8'd0;
      run = 1'b1;
      acc1 = 1'b0;
      repeat (12) begin
         cycles(1);
         acc1 = acc1 | speaker[0];
      end
      check("div0_silent", acc1, 1'b0);
      run = 1'b0;
      cycles(2);
      tone_div[7:0] = 8'd3;

      // Randomized traffic against the model.
      run = 1'b1;
      for (int i = 0; i < 600; i++) begin
         pat_we = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            pat_we   = 1'b1;
            pat_step = SW'($urandom_range(0, NUM_STEPS - 1));
            pat_data = NUM_CH'($urandom);
         end
         if ($urandom_range(0, 24) == 0) run = ~run;
         if ($urandom_range(0, 59) == 0) seq_len = 5'($urandom_range(0, 20));
         cycles(1);
      end
      pat_we  = 1'b0;
      seq_len = '0;
      run     = 1'b0;
      cycles(2);

      // Asynchronous reset mid-run with a full pattern loaded.
      for (int r = 0; r < NUM_STEPS; r++) write_row(r, 4'b1111);
      run = 1'b1;
      cycles(6);
      check("gate_before_reset", gate, 4'b1111);
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      cycles(3);
      run     = 1'b0;
      reset_n = 1'b1;
      cycles(3);
      check("idle_after_reset_tick", tick, 0);
      check("idle_after_reset_step", step, 0);
      run = 1'b1;
      acc = '0;
      repeat (90) begin
         cycles(1);
         acc = acc | gate;
      end
      check("pattern_cleared", acc, 0);

      run = 1'b0;
      cycles(3);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
